// File: rtl/synfifo_pkg.sv
// Shared definitions for the synfifo family: default geometry, pointer
// width helper and the registered error-pulse encoding.
package synfifo_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 16;

  // At most one error can be flagged per cycle. Overflow needs a full FIFO
  // and underflow an empty one, and these are exclusive for DEPTH >= 2.
  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_OVF  = 2'b01,
    ERR_UDF  = 2'b10
  } err_e;

  // Pointer width: address bits plus one wrap bit, so that full and empty
  // can be told apart when the address bits match.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/synfifo_mem.sv
// DEPTH x WIDTH storage for the synfifo family: one synchronous write port,
// one combinational read port. Contents are not reset.
module synfifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       CLK,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [WIDTH-1:0]           rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store the word on the clock edge when enabled.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/empty
// flags and registered overflow/underflow pulses.
// Optional macro SYNFIFO_FWFT_EN selects first-word-fall-through output;
// without it dOut is a registered read with one cycle of latency.
module sync_fifo_param
  import synfifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          wEN,
  input  logic                          rEN,
  input  logic [WIDTH-1:0]              dIn,
  output logic [WIDTH-1:0]              dOut,
  output logic                          bFull,
  output logic                          bEmpty,
  output logic                          bAlmostFull,
  output logic                          bAlmostEmpty,
  output logic [ptr_width(DEPTH)-1:0]   count,
  output logic                          ovf,
  output logic                          udf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] AF_CNT = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_CNT = PW'(AE_LEVEL);

  logic [PW-1:0]    w_ptr;
  logic [PW-1:0]    r_ptr;
  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH-1:0] head;
  err_e             err_q;
  err_e             err_d;

  // Status is derived purely from the registered pointers.
  assign bEmpty       = (w_ptr == r_ptr);
  assign bFull        = (w_ptr[AW] != r_ptr[AW]) && (w_ptr[AW-1:0] == r_ptr[AW-1:0]);
  assign count        = w_ptr - r_ptr;
  assign bAlmostFull  = (count >= AF_CNT);
  assign bAlmostEmpty = (count <= AE_CNT);

  assign wr_acc = wEN && !bFull;
  assign rd_acc = rEN && !bEmpty;

  synfifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .CLK     (CLK),
    .wr_en   (wr_acc),
    .wr_addr (w_ptr[AW-1:0]),
    .wr_data (dIn),
    .rd_addr (r_ptr[AW-1:0]),
    .rd_data (head)
  );

  // Pointer registers: advance only on accepted operations, wrap naturally.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (wr_acc) begin
        w_ptr <= w_ptr + 1'b1;
      end
      if (rd_acc) begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  // Classify this cycle's rejected request, if any.
  always_comb begin
    err_d = ERR_NONE;
    if (wEN && bFull) begin
      err_d = ERR_OVF;
    end else if (rEN && bEmpty) begin
      err_d = ERR_UDF;
    end
  end

  // Error register: one-cycle pulse following the offending request.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      err_q <= ERR_NONE;
    end else begin
      err_q <= err_d;
    end
  end

  assign ovf = (err_q == ERR_OVF);
  assign udf = (err_q == ERR_UDF);

`ifdef SYNFIFO_FWFT_EN
  logic [WIDTH-1:0] hold_q;

  // Shadow the head word while one exists; on draining, the popped word
  // remains here so dOut holds its last value while empty.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      hold_q <= '0;
    end else if (!bEmpty) begin
      hold_q <= head;
    end
  end

  assign dOut = bEmpty ? hold_q : head;
`else
  logic [WIDTH-1:0] dout_q;

  // Registered read: capture the head word on an accepted read only.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      dout_q <= '0;
    end else if (rd_acc) begin
      dout_q <= head;
    end
  end

  assign dOut = dout_q;
`endif

endmodule
